frame_buffer_stream_matrix: RTL and testbench

Streaming successor to the 3-row addressed frame buffer. It accepts a raster-order pixel stream and keeps a circular line buffer of P_KERNEL lines. For every pixel whose full KxK neighbourhood lies inside the frame, it emits the complete KxK window, centre included, for downstream convolution and edge-detection stages. Kernel size, frame size and pixel depth are all parameters, and there is no external addressing.

---
 rtl/frame_buffer_stream_matrix.sv | 224 ++++++++++++++++++++++
 tb/tb_frame_buffer_stream_matrix.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_stream_matrix.sv
// -----------------------------------------------------------------------------
// frame_buffer_stream_matrix
//
// Purpose:
//   Streaming KxK neighbourhood generator. A raster-order pixel stream is
//   written into a circular buffer of P_KERNEL lines. Every accepted pixel
//   pushes one K-tall column (oldest line at top, incoming pixel at bottom)
//   into a KxK window register. Whenever the accepted pixel completes a
//   neighbourhood that lies fully inside the frame, the whole window is
//   presented for one cycle on O_PIXEL_MATRIX.
//
// Ports:
//   I_CLK           clock, everything on the rising edge
//   I_RESET         synchronous, active-low reset
//   I_PIXEL         input pixel, P_PIXEL_DEPTH bits
//   I_VALID         I_PIXEL is valid this cycle
//   I_SOF           start of frame, current/next pixel is (row 0, col 0)
//   O_PIXEL_MATRIX  KxK window, row-major, top-left element in the MSBs
//   O_VALID         one-cycle pulse per window
//   O_EOF           high together with O_VALID on the last window of a frame
//   O_OVERFLOW      sticky flag, pixel arrived after the frame completed
//   O_ROW/O_COLUMN  window-centre coordinates (only with the macro below)
//
// Optional feature:
//   Define FRAME_BUFFER_COORD_OUT_EN to add the O_ROW / O_COLUMN ports.
// -----------------------------------------------------------------------------
module frame_buffer_stream_matrix #(
   parameter int P_COLUMNS     = 640,
   parameter int P_ROWS        = 480,
   parameter int P_PIXEL_DEPTH = 8,
   parameter int P_KERNEL      = 3,
   localparam int P_O_PIXEL_MATRIX_BIT_COUNT = P_PIXEL_DEPTH * P_KERNEL * P_KERNEL
) (
   input  logic                                  I_CLK,
   input  logic                                  I_RESET,
   input  logic [P_PIXEL_DEPTH-1:0]              I_PIXEL,
   input  logic                                  I_VALID,
   input  logic                                  I_SOF,
   output logic [P_O_PIXEL_MATRIX_BIT_COUNT-1:0] O_PIXEL_MATRIX,
   output logic                                  O_VALID,
   output logic                                  O_EOF,
`ifdef FRAME_BUFFER_COORD_OUT_EN
   output logic [$clog2(P_ROWS)-1:0]             O_ROW,
   output logic [$clog2(P_COLUMNS)-1:0]          O_COLUMN,
`endif
   output logic                                  O_OVERFLOW
);

   localparam int W  = P_PIXEL_DEPTH;
   localparam int K  = P_KERNEL;
   localparam int H  = (K - 1) / 2;
   localparam int CW = $clog2(P_COLUMNS);
   localparam int RW = $clog2(P_ROWS);
   localparam int SW = $clog2(K);
   localparam int BC = P_O_PIXEL_MATRIX_BIT_COUNT;

   localparam logic [CW-1:0] LAST_COL  = CW'(P_COLUMNS - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(P_ROWS - 1);
   localparam logic [CW-1:0] FIRST_WIN_COL = CW'(K - 1);
   localparam logic [RW-1:0] FIRST_WIN_ROW = RW'(K - 1);
   localparam logic [SW-1:0] LAST_SLOT = SW'(K - 1);
`ifdef FRAME_BUFFER_COORD_OUT_EN
   localparam logic [CW-1:0] HALF_COL  = CW'(H);
   localparam logic [RW-1:0] HALF_ROW  = RW'(H);
`endif

   // Elaboration-time guard: only odd kernels from 3 to 7 are meaningful.
   if ((K % 2) == 0 || K < 3 || K > 7) begin : g_bad_kernel
      $error("frame_buffer_stream_matrix: P_KERNEL must be odd and in 3..7");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_DONE
   } state_t;

   state_t          state;
   logic [RW-1:0]   in_row;
   logic [CW-1:0]   in_col;
   logic [SW-1:0]   wr_slot;

   logic [W-1:0]    line_mem [K][P_COLUMNS];
   logic [W-1:0]    window   [K][K];

   logic            accept;
   logic [RW-1:0]   eff_row;
   logic [CW-1:0]   eff_col;
   logic [SW-1:0]   eff_slot;
   logic [W-1:0]    column      [K];
   logic [W-1:0]    next_window [K][K];
   logic [BC-1:0]   next_flat;
   logic            win_ready;
   logic            frame_end;

   // Slot that held the line 'age' lines above the one in slot 'cur'.
   function automatic logic [SW-1:0] older_slot(input logic [SW-1:0] cur, input int age);
      int t;
      t = int'(cur) - age;
      if (t < 0) begin
         t = t + K;
      end
      return SW'(t);
   endfunction

   // A start-of-frame pixel is taken as (0,0) regardless of where the
   // counters currently point, so every position-dependent decision works
   // on these "effective" coordinates rather than the raw registers.
   always_comb begin
      accept   = I_VALID && ((state == S_ACTIVE) || I_SOF);
      eff_row  = I_SOF ? '0 : in_row;
      eff_col  = I_SOF ? '0 : in_col;
      eff_slot = I_SOF ? '0 : wr_slot;
      win_ready = (eff_row >= FIRST_WIN_ROW) && (eff_col >= FIRST_WIN_COL);
      frame_end = (eff_row == LAST_ROW) && (eff_col == LAST_COL);
   end

   // Assemble the incoming K-tall column: the K-1 older lines come straight
   // out of the line buffer, the bottom element is the live pixel, which is
   // being written into its own slot on this same edge.
   always_comb begin
      for (int i = 0; i < K; i++) begin
         column[i] = '0;
      end
      column[K-1] = I_PIXEL;
      for (int a = 1; a < K; a++) begin
         column[K-1-a] = line_mem[older_slot(eff_slot, a)][eff_col];
      end
   end

   // Shift the window one column to the left and append the new column on
   // the right, then flatten it row-major with the top-left element in the
   // most significant position.
   always_comb begin
      next_flat = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            if (j < K - 1) begin
               next_window[i][j] = window[i][j+1];
            end else begin
               next_window[i][j] = column[i];
            end
         end
      end
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            next_flat[W*(K*K-1-(i*K+j)) +: W] = next_window[i][j];
         end
      end
   end

   // Line buffer write port. The memory is deliberately never cleared:
   // anything stale is kept off the output by the window-valid condition.
   always_ff @(posedge I_CLK) begin
      if (I_RESET && accept) begin
         line_mem[eff_slot][eff_col] <= I_PIXEL;
      end
   end

   // Frame sequencer, position counters, window register and all outputs.
   // A start of frame restarts everything; later assignments in the accept
   // branch deliberately override the restart values for the (0,0) pixel.
   always_ff @(posedge I_CLK) begin
      if (!I_RESET) begin
         state          <= S_IDLE;
         in_row         <= '0;
         in_col         <= '0;
         wr_slot        <= '0;
         window         <= '{default: '0};
         O_PIXEL_MATRIX <= '0;
         O_VALID        <= 1'b0;
         O_EOF          <= 1'b0;
         O_OVERFLOW     <= 1'b0;
`ifdef FRAME_BUFFER_COORD_OUT_EN
         O_ROW          <= '0;
         O_COLUMN       <= '0;
`endif
      end else begin
         O_VALID <= 1'b0;
         O_EOF   <= 1'b0;

         if (I_SOF) begin
            state      <= S_ACTIVE;
            in_row     <= '0;
            in_col     <= '0;
            wr_slot    <= '0;
            O_OVERFLOW <= 1'b0;
         end else if (state == S_DONE && I_VALID) begin
            O_OVERFLOW <= 1'b1;
         end

         if (accept) begin
            window <= next_window;

            if (eff_col == LAST_COL) begin
               in_col <= '0;
               if (eff_row == LAST_ROW) begin
                  state   <= S_DONE;
                  in_row  <= '0;
                  wr_slot <= '0;
               end else begin
                  in_row  <= eff_row + RW'(1);
                  wr_slot <= (eff_slot == LAST_SLOT) ? '0 : eff_slot + SW'(1);
               end
            end else begin
               in_col  <= eff_col + CW'(1);
               in_row  <= eff_row;
               wr_slot <= eff_slot;
            end

            if (win_ready) begin
               O_VALID        <= 1'b1;
               O_EOF          <= frame_end;
               O_PIXEL_MATRIX <= next_flat;
`ifdef FRAME_BUFFER_COORD_OUT_EN
               O_ROW          <= eff_row - HALF_ROW;
               O_COLUMN       <= eff_col - HALF_COL;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_buffer_stream_matrix.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_stream_matrix
//
// Two instances: a K=3 8x4 frame and a K=5 8x6 frame. Pixel value is
// row*16+col. Expected windows are queued when the completing pixel is
// driven; independent monitors pop and compare whenever O_VALID is seen.
// -----------------------------------------------------------------------------
module tb_frame_buffer_stream_matrix;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [7:0]  pix3, pix5;
   logic        v3, s3, v5, s5;
   logic [71:0] mat3;
   logic [199:0] mat5;
   logic        ov3, eof3, ovf3, ov5, eof5, ovf5;
`ifdef FRAME_BUFFER_COORD_OUT_EN
   logic [1:0]  row3;
   logic [2:0]  col3, row5, col5;
   int          first_r5, first_c5, last_r5, last_c5;
`endif

   int checks = 0;
   int errors = 0;

   logic [199:0] exp_mat3_q[$], exp_mat5_q[$];
   logic         exp_eof3_q[$], exp_eof5_q[$];
   int           exp_r3_q[$], exp_c3_q[$], exp_r5_q[$], exp_c5_q[$];

   int           win_count3, win_count5;
   logic [71:0]  first_mat3, last_mat3;
   logic [199:0] first_mat5, last_mat5;
   logic         last_eof3, last_eof5;
   logic         gap_mode = 1'b0;
   logic         prev_ov3 = 1'b0;

   frame_buffer_stream_matrix #(
      .P_COLUMNS(8), .P_ROWS(4), .P_PIXEL_DEPTH(8), .P_KERNEL(3)
   ) dut3 (
      .I_CLK(clk), .I_RESET(rst_n), .I_PIXEL(pix3), .I_VALID(v3), .I_SOF(s3),
      .O_PIXEL_MATRIX(mat3), .O_VALID(ov3), .O_EOF(eof3),
`ifdef FRAME_BUFFER_COORD_OUT_EN
      .O_ROW(row3), .O_COLUMN(col3),
`endif
      .O_OVERFLOW(ovf3)
   );

   frame_buffer_stream_matrix #(
      .P_COLUMNS(8), .P_ROWS(6), .P_PIXEL_DEPTH(8), .P_KERNEL(5)
   ) dut5 (
      .I_CLK(clk), .I_RESET(rst_n), .I_PIXEL(pix5), .I_VALID(v5), .I_SOF(s5),
      .O_PIXEL_MATRIX(mat5), .O_VALID(ov5), .O_EOF(eof5),
`ifdef FRAME_BUFFER_COORD_OUT_EN
      .O_ROW(row5), .O_COLUMN(col5),
`endif
      .O_OVERFLOW(ovf5)
   );

   // Expected window centred at (cr,cc) for a ramp frame.
   function automatic logic [199:0] build_window(input int k, input int cr, input int cc);
      logic [199:0] res;
      int h;
      res = '0;
      h = (k - 1) / 2;
      for (int i = 0; i < k; i++) begin
         for (int j = 0; j < k; j++) begin
            res[8*(k*k-1-(i*k+j)) +: 8] = 8'((cr - h + i) * 16 + (cc - h + j));
         end
      end
      return res;
   endfunction

   task automatic checkOutput(input string name, input logic [199:0] actual, input logic [199:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
      end
   endtask

   // Drive one clock worth of inputs to the selected instance.
   task automatic applyStimulus(input int sel, input logic valid, input logic sof,
                                input logic [7:0] pixel, input logic rst_val);
      rst_n = rst_val;
      if (sel == 0) begin
         v3 = valid; s3 = sof; pix3 = pixel; v5 = 1'b0; s5 = 1'b0; pix5 = 8'h00;
      end else begin
         v5 = valid; s5 = sof; pix5 = pixel; v3 = 1'b0; s3 = 1'b0; pix3 = 8'h00;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_window(input int sel, input int k, input int r, input int c, input logic eof);
      int h;
      h = (k - 1) / 2;
      if (sel == 0) begin
         exp_mat3_q.push_back(build_window(k, r - h, c - h));
         exp_eof3_q.push_back(eof);
         exp_r3_q.push_back(r - h);
         exp_c3_q.push_back(c - h);
      end else begin
         exp_mat5_q.push_back(build_window(k, r - h, c - h));
         exp_eof5_q.push_back(eof);
         exp_r5_q.push_back(r - h);
         exp_c5_q.push_back(c - h);
      end
   endtask

   task automatic send_frame(input int sel, input int rows, input int k,
                             input logic gap, input logic check_ovf_clear);
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (r >= k - 1 && c >= k - 1) begin
               push_window(sel, k, r, c, (r == rows - 1) && (c == 7));
            end
            applyStimulus(sel, 1'b1, (r == 0) && (c == 0), 8'(r * 16 + c), 1'b1);
            if (check_ovf_clear && r == 0 && c == 0) begin
               checkOutput("ovf_cleared_by_sof", {199'b0, ovf3}, 200'd0);
            end
            if (gap) begin
               applyStimulus(sel, 1'b0, 1'b0, 8'h00, 1'b1);
            end
         end
      end
      repeat (3) applyStimulus(sel, 1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   // Monitor for the K=3 instance.
   always @(negedge clk) begin
      logic [199:0] e;
      logic         ee;
      int           er, ec;
      if (ov3) begin
         win_count3++;
         if (win_count3 == 1) first_mat3 = mat3;
         last_mat3 = mat3;
         last_eof3 = eof3;
         checks++;
         if (exp_mat3_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_window3 got %h expected no window", mat3);
         end else begin
            e  = exp_mat3_q.pop_front();
            ee = exp_eof3_q.pop_front();
            er = exp_r3_q.pop_front();
            ec = exp_c3_q.pop_front();
            if (mat3 !== e[71:0] || eof3 !== ee) begin
               errors++;
               $display("[TB] FAIL window3 got %h eof %b expected %h eof %b", mat3, eof3, e[71:0], ee);
            end
`ifdef FRAME_BUFFER_COORD_OUT_EN
            checks++;
            if (int'(row3) != er || int'(col3) != ec) begin
               errors++;
               $display("[TB] FAIL coord3 got (%0d,%0d) expected (%0d,%0d)", row3, col3, er, ec);
            end
`endif
         end
         if (gap_mode) begin
            checks++;
            if (prev_ov3) begin
               errors++;
               $display("[TB] FAIL back_to_back3 got consecutive O_VALID expected gap");
            end
         end
      end
      prev_ov3 = ov3;
   end

   // Monitor for the K=5 instance.
   always @(negedge clk) begin
      logic [199:0] e;
      logic         ee;
      int           er, ec;
      if (ov5) begin
         win_count5++;
         if (win_count5 == 1) first_mat5 = mat5;
         last_mat5 = mat5;
         last_eof5 = eof5;
         checks++;
         if (exp_mat5_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_window5 got %h expected no window", mat5);
         end else begin
            e  = exp_mat5_q.pop_front();
            ee = exp_eof5_q.pop_front();
            er = exp_r5_q.pop_front();
            ec = exp_c5_q.pop_front();
            if (mat5 !== e || eof5 !== ee) begin
               errors++;
               $display("[TB] FAIL window5 got %h eof %b expected %h eof %b", mat5, eof5, e, ee);
            end
`ifdef FRAME_BUFFER_COORD_OUT_EN
            if (win_count5 == 1) begin first_r5 = int'(row5); first_c5 = int'(col5); end
            last_r5 = int'(row5);
            last_c5 = int'(col5);
            checks++;
            if (int'(row5) != er || int'(col5) != ec) begin
               errors++;
               $display("[TB] FAIL coord5 got (%0d,%0d) expected (%0d,%0d)", row5, col5, er, ec);
            end
`endif
         end
      end
   end

   // Global time bound so the bench always reaches an end.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      win_count3 = 0;
      win_count5 = 0;
      rst_n = 1'b0;
      v3 = 1'b0; s3 = 1'b0; pix3 = 8'h00;
      v5 = 1'b0; s5 = 1'b0; pix5 = 8'h00;

      // Reset values.
      applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("reset_valid3",  {199'b0, ov3},  200'd0);
      checkOutput("reset_matrix3", {128'b0, mat3}, 200'd0);
      checkOutput("reset_eof3",    {199'b0, eof3}, 200'd0);
      checkOutput("reset_ovf3",    {199'b0, ovf3}, 200'd0);
      checkOutput("reset_matrix5", mat5,           200'd0);

      // 1: ramp frame, continuous valid.
      win_count3 = 0;
      send_frame(0, 4, 3, 1'b0, 1'b0);
      checkOutput("t1_count",        200'(win_count3),     200'd12);
      checkOutput("t1_first_tl",     {192'b0, first_mat3[71:64]}, 200'h00);
      checkOutput("t1_first_centre", {192'b0, first_mat3[39:32]}, 200'h11);
      checkOutput("t1_first_br",     {192'b0, first_mat3[7:0]},   200'h22);
      checkOutput("t1_last_centre",  {192'b0, last_mat3[39:32]},  200'h26);
      checkOutput("t1_last_br",      {192'b0, last_mat3[7:0]},    200'h37);
      checkOutput("t1_last_eof",     {199'b0, last_eof3},         200'd1);

      // 2: same frame with a gap after every pixel.
      win_count3 = 0;
      gap_mode = 1'b1;
      send_frame(0, 4, 3, 1'b1, 1'b0);
      gap_mode = 1'b0;
      checkOutput("t2_count", 200'(win_count3), 200'd12);

      // 3: extra pixels after the frame, then a new frame.
      win_count3 = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1'b1, 1'b0, 8'hAA, 1'b1);
      end
      checkOutput("t3_ovf_set", {199'b0, ovf3}, 200'd1);
      repeat (3) applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("t3_ovf_held", {199'b0, ovf3}, 200'd1);
      checkOutput("t3_no_windows", 200'(win_count3), 200'd0);
      send_frame(0, 4, 3, 1'b0, 1'b1);
      checkOutput("t3_count", 200'(win_count3), 200'd12);

      // 4: reset, then pixels without start of frame.
      applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0);
      win_count3 = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1'b1, 1'b0, 8'(i), 1'b1);
      end
      repeat (2) applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("t4_ovf", {199'b0, ovf3}, 200'd0);
      checkOutput("t4_no_windows", 200'(win_count3), 200'd0);
      send_frame(0, 4, 3, 1'b0, 1'b0);
      checkOutput("t4_count", 200'(win_count3), 200'd12);

      // 5: reset in the middle of a frame, just after pixel (2,3).
      win_count3 = 0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (r < 2 || c <= 3) begin
               if (r >= 2 && c >= 2) push_window(0, 3, r, c, 1'b0);
               applyStimulus(0, 1'b1, (r == 0) && (c == 0), 8'(r * 16 + c), 1'b1);
            end
         end
      end
      applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("t5_valid_after_reset",  {199'b0, ov3},  200'd0);
      checkOutput("t5_matrix_after_reset", {128'b0, mat3}, 200'd0);
      checkOutput("t5_eof_after_reset",    {199'b0, eof3}, 200'd0);
      checkOutput("t5_ovf_after_reset",    {199'b0, ovf3}, 200'd0);
      for (int r = 2; r < 4; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (r > 2 || c > 3) applyStimulus(0, 1'b1, 1'b0, 8'(r * 16 + c), 1'b1);
         end
      end
      repeat (2) applyStimulus(0, 1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("t5_windows_before_abort", 200'(win_count3), 200'd2);
      win_count3 = 0;
      send_frame(0, 4, 3, 1'b0, 1'b0);
      checkOutput("t5_count", 200'(win_count3), 200'd12);

      // 6: K=5, six rows.
      win_count5 = 0;
      send_frame(1, 6, 5, 1'b0, 1'b0);
      checkOutput("t6_count",        200'(win_count5),              200'd8);
      checkOutput("t6_first_tl",     {192'b0, first_mat5[199:192]}, 200'h00);
      checkOutput("t6_first_centre", {192'b0, first_mat5[103:96]},  200'h22);
      checkOutput("t6_first_br",     {192'b0, first_mat5[7:0]},     200'h44);
      checkOutput("t6_last_centre",  {192'b0, last_mat5[103:96]},   200'h35);
      checkOutput("t6_last_br",      {192'b0, last_mat5[7:0]},      200'h57);
      checkOutput("t6_last_eof",     {199'b0, last_eof5},           200'd1);
`ifdef FRAME_BUFFER_COORD_OUT_EN
      checkOutput("t6_first_row", 200'(first_r5), 200'd2);
      checkOutput("t6_first_col", 200'(first_c5), 200'd2);
      checkOutput("t6_last_row",  200'(last_r5),  200'd3);
      checkOutput("t6_last_col",  200'(last_c5),  200'd5);
`endif

      // Every queued window must have been seen.
      checkOutput("queue3_drained", 200'(exp_mat3_q.size()), 200'd0);
      checkOutput("queue5_drained", 200'(exp_mat5_q.size()), 200'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
